// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared constants and types for the CP0 exception controller
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_PRID       = 32'h0000_0717;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  // EXL state: NORMAL is EXL=0, HANDLER is EXL=1
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline-to-CP0 signal bundle
interface cp0_exc_ctrl_if;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        int_req;
  logic        exc_entry;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  // pipeline side
  modport master (
    output rd_addr, wr_addr, wr_data, wr_en, pc_m, bd_m,
           exc_valid_m, exc_code_m, eret_m, hw_int,
    input  rd_data, int_req, exc_entry, handler_pc, epc_out
  );

  // CP0 side
  modport slave (
    input  rd_addr, wr_addr, wr_data, wr_en, pc_m, bd_m,
           exc_valid_m, exc_code_m, eret_m, hw_int,
    output rd_data, int_req, exc_entry, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 SR/Cause/EPC/PRId with M-stage exception commit
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = DEF_PRID,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
  input  logic              clk,
  input  logic              reset,
  cp0_exc_ctrl_if.slave     bus
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        exl;
  logic        int_req;
  logic        exc_entry;

  assign exl       = (state_q == ST_HANDLER);
  // Interrupt uses the live lines, not IP, so it is taken in the same cycle it rises
  assign int_req   = (|(bus.hw_int & im_q)) & ie_q & ~exl;
  assign exc_entry = int_req | (bus.exc_valid_m & ~exl);

  assign bus.int_req    = int_req;
  assign bus.exc_entry  = exc_entry;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.epc_out    = epc_q;

  // State register and CP0 register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_NORMAL;
      im_q      <= '0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      im_q      <= im_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // Next state: entry beats mtc0; eret clears EXL after any SR write in the same cycle
  always_comb begin
    state_d   = state_q;
    im_d      = im_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ip_d      = bus.hw_int;

    if (exc_entry) begin
      state_d   = ST_HANDLER;
      exccode_d = int_req ? EXC_INT : bus.exc_code_m;
      bd_d      = bus.bd_m;
      epc_d     = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end else begin
      if (bus.wr_en) begin
        if (bus.wr_addr == REG_SR) begin
          im_d    = bus.wr_data[SR_IM_HI:SR_IM_LO];
          ie_d    = bus.wr_data[SR_IE];
          state_d = bus.wr_data[SR_EXL] ? ST_HANDLER : ST_NORMAL;
        end else if (bus.wr_addr == REG_EPC) begin
          epc_d   = bus.wr_data;
        end
      end
      if (bus.eret_m && exl) begin
        state_d = ST_NORMAL;
      end
    end
  end

  // mfc0 read mux from registered state only
  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_addr)
      REG_SR:    bus.rd_data = {16'b0, im_q, 8'b0, exl, ie_q};
      REG_CAUSE: bus.rd_data = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
      REG_EPC:   bus.rd_data = epc_q;
      REG_PRID:  bus.rd_data = PRID;
      default:   bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic eret();
    bus.eret_m = 1'b1;
    step();
    bus.eret_m = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
    bus.pc_m = '0; bus.bd_m = 1'b0; bus.exc_valid_m = 1'b0; bus.exc_code_m = '0;
    bus.eret_m = 1'b0; bus.hw_int = '0;

    // reset
    step(); step();
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd15, "rst_prid", 32'h0000_0717);
    rd(5'd3,  "rst_unimpl", 32'h0);
    check("rst_int_req", {31'b0, bus.int_req}, 32'h0);
    check("rst_exc_entry", {31'b0, bus.exc_entry}, 32'h0);
    check("rst_epc_out", bus.epc_out, 32'h0);
    check("handler_pc", bus.handler_pc, 32'h0000_4180);
    reset = 1'b1;

    // interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_write", 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.pc_m = 32'h3010; bus.bd_m = 1'b0;
    #1;
    check("irq_entry", {31'b0, bus.exc_entry}, 32'h1);
    check("irq_req", {31'b0, bus.int_req}, 32'h1);
    step();
    rd(5'd14, "irq_epc", 32'h0000_3010);
    rd(5'd13, "irq_cause", 32'h0000_0400);
    rd(5'd12, "irq_sr_exl", 32'h0000_0403);
    check("irq_held_no_entry", {31'b0, bus.exc_entry}, 32'h0);

    // eret with interrupt still pending
    bus.eret_m = 1'b1;
    #1;
    check("eret_no_entry", {31'b0, bus.exc_entry}, 32'h0);
    check("eret_epc_out", bus.epc_out, 32'h0000_3010);
    step();
    bus.eret_m = 1'b0;
    #1;
    rd(5'd12, "eret_sr", 32'h0000_0401);
    check("eret_reentry", {31'b0, bus.exc_entry}, 32'h1);
    check("eret_epc_out2", bus.epc_out, 32'h0000_3010);
    step();
    bus.hw_int = 6'b0;
    eret();

    // delay-slot overflow
    bus.exc_valid_m = 1'b1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3024; bus.bd_m = 1'b1;
    #1;
    check("ov_entry", {31'b0, bus.exc_entry}, 32'h1);
    check("ov_no_irq", {31'b0, bus.int_req}, 32'h0);
    step();
    bus.exc_valid_m = 1'b0;
    rd(5'd14, "ov_epc", 32'h0000_3020);
    rd(5'd13, "ov_cause", 32'h8000_0030);

    // exception while EXL=1 is ignored
    bus.exc_valid_m = 1'b1; bus.exc_code_m = 5'd4; bus.pc_m = 32'h5000; bus.bd_m = 1'b0;
    #1;
    check("exl_ignore_entry", {31'b0, bus.exc_entry}, 32'h0);
    step();
    bus.exc_valid_m = 1'b0;
    rd(5'd14, "exl_ignore_epc", 32'h0000_3020);
    rd(5'd13, "exl_ignore_cause", 32'h8000_0030);
    eret();

    // interrupt + exception + mtc0 EPC all in one cycle
    bus.hw_int = 6'b000001; bus.exc_valid_m = 1'b1; bus.exc_code_m = 5'd10;
    bus.pc_m = 32'h4000; bus.bd_m = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'hDEAD_BEEF;
    step();
    bus.wr_en = 1'b0; bus.exc_valid_m = 1'b0;
    rd(5'd13, "sim_cause", 32'h0000_0400);
    rd(5'd14, "sim_epc", 32'h0000_4000);
    bus.hw_int = 6'b0;
    eret();

    // delay slot at pc 0 wraps
    bus.exc_valid_m = 1'b1; bus.exc_code_m = 5'd5; bus.pc_m = 32'h0; bus.bd_m = 1'b1;
    step();
    bus.exc_valid_m = 1'b0; bus.bd_m = 1'b0;
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0014);
    eret();

    // masking: IE=1, IM=0
    mtc0(5'd12, 32'h0000_0001);
    bus.hw_int = 6'b111111;
    #1;
    check("mask_int_req", {31'b0, bus.int_req}, 32'h0);
    check("mask_exc_entry", {31'b0, bus.exc_entry}, 32'h0);
    step();
    rd(5'd13, "mask_ip", 32'h8000_FC14);

    // writes to Cause and PRId are discarded
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h8000_FC14);
    mtc0(5'd15, 32'h1234_5678);
    rd(5'd15, "prid_ro", 32'h0000_0717);

    // reset in the middle of a handler
    mtc0(5'd12, 32'h0000_FC03);
    rd(5'd12, "pre_rst_sr", 32'h0000_FC03);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    rd(5'd12, "midrst_sr", 32'h0);
    rd(5'd14, "midrst_epc", 32'h0);
    check("midrst_int_req", {31'b0, bus.int_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
